// File: rtl/fsm_periferico.sv
// -----------------------------------------------------------------------------
// fsm_periferico
//   Peripheral-side responder for the processor send/ack handshake. Each word
//   offered with send==01 is captured into a local circular FIFO and answered
//   with a 4-phase handshake on ack. A local consumer drains the FIFO via rd_en.
//
// Parameters
//   DEPTH      FIFO entries (power of two, >= 2)
//   ACK_DELAY  extra cycles spent in WAIT before ack is raised (0..15)
//
// Ports
//   clk       in   single clock, all logic on posedge
//   rst       in   asynchronous active-low reset
//   send      in   [1:0] 01 = request, 00 = idle, 1x = illegal
//   dado      in   [15:0] data word, sampled only on the capture edge
//   ack       out  [1:0] 01 = word accepted, 00 = idle
//   rd_en     in   pop head word (ignored when empty)
//   data_out  out  [15:0] FIFO head word, valid while !empty
//   empty     out  FIFO holds 0 words
//   full      out  FIFO holds DEPTH words
//   count     out  [$clog2(DEPTH):0] words held
//   rx_total  out  [15:0] words accepted since reset, wraps
//   err       out  sticky illegal-send flag
// -----------------------------------------------------------------------------
module fsm_periferico #(
  parameter int DEPTH     = 4,
  parameter int ACK_DELAY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               send,
  input  logic [15:0]              dado,
  output logic [1:0]               ack,
  input  logic                     rd_en,
  output logic [15:0]              data_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              rx_total,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  // WAIT exits when the counter reads zero, so it is loaded with D-1.
  localparam logic [3:0] DLY_LOAD = (ACK_DELAY == 0) ? 4'd0 : 4'(ACK_DELAY - 1);

  logic [1:0]    state, next_state;
  logic [3:0]    dly_cnt;
  logic          req, wr, pop;

  logic [15:0]   mem [DEPTH];
  logic [CW-1:0] rd_ptr, wr_ptr, count_n, head_n;

  // Illegal codes (1x) are not a request, so they behave like 00.
  assign req = (send == 2'b01);
  // Write is decided on the pre-pop full flag: a full FIFO refuses the word
  // even if the consumer pops in the same cycle.
  assign wr  = (state == S_IDLE) && req && !full;
  assign pop = rd_en && !empty;

  // NOTE: combinational blocks assign every output a default first so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (wr) next_state = (ACK_DELAY == 0) ? S_ACK : S_WAIT;
      S_WAIT: if (dly_cnt == 4'd0) next_state = S_ACK;
      S_ACK:  if (!req) next_state = S_REL;
      S_REL:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ack     <= 2'b00;
      dly_cnt <= 4'd0;
      err     <= 1'b0;
    end else begin
      state <= next_state;
      // ack is registered from the next state so it changes on the same
      // edge as the state it reflects.
      ack   <= {1'b0, next_state == S_ACK};
      if (wr)
        dly_cnt <= DLY_LOAD;
      else if (state == S_WAIT && dly_cnt != 4'd0)
        dly_cnt <= dly_cnt - 4'd1;
      if (send[1])
        err <= 1'b1;
    end
  end

  // NOTE: the storage array carries no reset; only pointers and flags do,
  // and data_out is forced to zero separately, so stale words are never seen.
  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr[AW-1:0]] <= dado;
  end

  assign count_n = count + CW'(wr) - CW'(pop);
  assign head_n  = pop ? rd_ptr + CW'(1) : rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      data_out <= 16'h0000;
      rx_total <= 16'h0000;
    end else begin
      if (wr) begin
        wr_ptr   <= wr_ptr + CW'(1);
        rx_total <= rx_total + 16'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + CW'(1);
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
      // Registered head: when the next head slot is the one being written
      // this edge, bypass the array and present dado directly.
      if (count_n != '0) begin
        if (wr && head_n[AW-1:0] == wr_ptr[AW-1:0])
          data_out <= dado;
        else
          data_out <= mem[head_n[AW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_fsm_periferico.sv
// -----------------------------------------------------------------------------
// tb_fsm_periferico
//   Drives two instances (ACK_DELAY=0 and ACK_DELAY=3, DEPTH=4) from shared
//   stimulus. A queue-and-timestamp model tracks each instance; a compare
//   process checks every output on every falling clock edge, and directed
//   sections pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_fsm_periferico;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  send = 2'b00;
  logic [15:0] dado = 16'h0000;
  logic        rd_en = 1'b0;

  logic [1:0]  ack0, ack3;
  logic [15:0] data_out0, data_out3, rx0, rx3;
  logic        empty0, empty3, full0, full3, err0, err3;
  logic [2:0]  count0, count3;

  always #5 clk = ~clk;

  fsm_periferico #(.DEPTH(DEPTH), .ACK_DELAY(0)) d0 (
    .clk(clk), .rst(rst), .send(send), .dado(dado), .ack(ack0), .rd_en(rd_en),
    .data_out(data_out0), .empty(empty0), .full(full0), .count(count0),
    .rx_total(rx0), .err(err0));

  fsm_periferico #(.DEPTH(DEPTH), .ACK_DELAY(3)) d3 (
    .clk(clk), .rst(rst), .send(send), .dado(dado), .ack(ack3), .rd_en(rd_en),
    .data_out(data_out3), .empty(empty3), .full(full3), .count(count3),
    .rx_total(rx3), .err(err3));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: FIFO contents as a queue; the handshake as timestamps.
  // acc = edge that accepted the word, drop = edge that saw send leave 01
  // while ack was high. ack is high from edge acc+D until drop; the responder
  // is idle again from edge drop+2 onward.
  // ---------------------------------------------------------------------------
  int          dl [2] = '{0, 3};
  logic [15:0] mq [2][$];
  bit          hs [2] = '{0, 0};
  int          acc [2] = '{0, 0};
  int          drop [2] = '{-1, -1};
  logic [15:0] m_total [2] = '{16'h0, 16'h0};
  logic [15:0] m_last [2] = '{16'h0, 16'h0};
  bit          m_err [2] = '{0, 0};
  int          edge_n = 0;

  function automatic bit exp_ack(input int k);
    return hs[k] && drop[k] < 0 && edge_n >= acc[k] + dl[k];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        hs[k] = 0;
        drop[k] = -1;
        m_total[k] = 16'h0;
        m_last[k] = 16'h0;
        m_err[k] = 0;
      end
    end else begin
      edge_n++;
      for (int k = 0; k < 2; k++) begin
        bit pop_m, wr_m;
        pop_m = rd_en && mq[k].size() > 0;
        if (hs[k] && drop[k] >= 0 && edge_n > drop[k] + 1) hs[k] = 0;
        wr_m = !hs[k] && send == 2'b01 && mq[k].size() < DEPTH;
        if (hs[k] && drop[k] < 0 && edge_n > acc[k] + dl[k] && send != 2'b01)
          drop[k] = edge_n;
        if (wr_m) begin
          hs[k] = 1;
          acc[k] = edge_n;
          drop[k] = -1;
        end
        if (send[1]) m_err[k] = 1;
        if (pop_m) void'(mq[k].pop_front());
        if (wr_m) begin
          mq[k].push_back(dado);
          m_total[k] = m_total[k] + 16'd1;
        end
        if (mq[k].size() > 0) m_last[k] = mq[k][0];
      end
    end
  end

  task automatic cmp(input int k, input logic [1:0] a, input logic [15:0] d,
                     input logic e, input logic f, input logic [2:0] c,
                     input logic [15:0] t, input logic r);
    int sz;
    sz = mq[k].size();
    check($sformatf("dut%0d_ack", k), 32'(a), {31'd0, exp_ack(k)});
    check($sformatf("dut%0d_count", k), 32'(c), 32'(sz));
    check($sformatf("dut%0d_empty", k), 32'(e), {31'd0, sz == 0});
    check($sformatf("dut%0d_full", k), 32'(f), {31'd0, sz == DEPTH});
    check($sformatf("dut%0d_data_out", k), 32'(d), 32'(m_last[k]));
    check($sformatf("dut%0d_rx_total", k), 32'(t), 32'(m_total[k]));
    check($sformatf("dut%0d_err", k), 32'(r), {31'd0, m_err[k]});
  endtask

  always @(negedge clk) begin
    cmp(0, ack0, data_out0, empty0, full0, count0, rx0, err0);
    cmp(1, ack3, data_out3, empty3, full3, count3, rx3, err3);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input string nm);
    int n;
    n = 0;
    while (!(ack0 == 2'b01 && ack3 == 2'b01) && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_ack_timeout"}, 32'(n < 20), 32'd1);
  endtask

  // One full handshake on both instances; dado is scrambled after capture.
  task automatic handshake(input logic [15:0] w, input logic pop_on_capture);
    send = 2'b01;
    dado = w;
    rd_en = pop_on_capture;
    tick();
    rd_en = 1'b0;
    dado = 16'hDEAD;
    wait_acks("hs");
    send = 2'b00;
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for 3 cycles with send toggling.
    rst = 1'b0;
    send = 2'b01; tick();
    send = 2'b00; tick();
    send = 2'b01; tick();
    check("rst_ack", 32'(ack0), 32'h0);
    check("rst_empty", 32'(empty0), 32'h1);
    check("rst_count", 32'(count0), 32'h0);
    check("rst_rx", 32'(rx0), 32'h0);
    check("rst_err", 32'(err0), 32'h0);
    check("rst_data", 32'(data_out0), 32'h0);
    send = 2'b00;
    rst = 1'b1;
    tick();

    // Single word, both delays.
    send = 2'b01; dado = 16'hA5A5;
    tick();
    check("t2_ack0", 32'(ack0), 32'h1);
    check("t2_data0", 32'(data_out0), 32'hA5A5);
    check("t2_count0", 32'(count0), 32'h1);
    check("t2_ack3_N", 32'(ack3), 32'h0);
    check("t2_count3", 32'(count3), 32'h1);
    dado = 16'h1234;
    tick(); tick();
    check("t2_ack3_N2", 32'(ack3), 32'h0);
    tick();
    check("t2_ack3_N3", 32'(ack3), 32'h1);
    send = 2'b00;
    tick();
    check("t2_rel_ack0", 32'(ack0), 32'h0);
    check("t2_rel_ack3", 32'(ack3), 32'h0);
    tick();
    check("t2_data_kept", 32'(data_out0), 32'hA5A5);

    // Backpressure with DEPTH=4.
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t3_drained", 32'(empty0), 32'h1);
    for (int i = 1; i <= 4; i++) handshake(16'(i), 1'b0);
    check("t3_full", 32'(full0), 32'h1);
    check("t3_count4", 32'(count0), 32'h4);
    send = 2'b01; dado = 16'h0005;
    repeat (5) tick();
    check("t3_bp_ack", 32'(ack0), 32'h0);
    check("t3_bp_count", 32'(count0), 32'h4);
    check("t3_bp_head", 32'(data_out0), 32'h0001);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t3_pop_head", 32'(data_out0), 32'h0002);
    check("t3_pop_count", 32'(count0), 32'h3);
    check("t3_pop_noack", 32'(ack0), 32'h0);
    tick();
    check("t3_w5_count", 32'(count0), 32'h4);
    check("t3_w5_ack", 32'(ack0), 32'h1);
    check("t3_w5_rx", 32'(rx0), 32'h6);
    wait_acks("t3");
    send = 2'b00; tick(); tick();

    // Pop + write on the capture edge at count=2, across pointer wrap.
    rd_en = 1'b1; tick(); tick(); rd_en = 1'b0;
    check("t4_start_count", 32'(count0), 32'h2);
    check("t4_start_head", 32'(data_out0), 32'h0004);
    for (int i = 0; i < 8; i++) begin
      handshake(16'h0010 + 16'(i), 1'b1);
      check("t4_count", 32'(count0), 32'h2);
    end
    check("t4_head_a", 32'(data_out0), 32'h0016);
    rd_en = 1'b1; tick();
    check("t4_head_b", 32'(data_out0), 32'h0017);
    tick(); rd_en = 1'b0;
    check("t4_empty", 32'(empty0), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      send = (r < 60) ? 2'b01 : (r < 97) ? 2'b00 : {1'b1, 1'($urandom)};
      dado = 16'($urandom);
      rd_en = ($urandom_range(0, 3) == 0);
      tick();
    end
    send = 2'b00; rd_en = 1'b0;

    // Illegal codes.
    rst = 1'b0; tick(); rst = 1'b1; tick();
    check("t5_err_clear", 32'(err0), 32'h0);
    send = 2'b11; tick();
    check("t5_err_set", 32'(err0), 32'h1);
    check("t5_ill_ack", 32'(ack0), 32'h0);
    check("t5_ill_count", 32'(count0), 32'h0);
    send = 2'b00; tick();
    send = 2'b01; dado = 16'hBEEF; tick();
    check("t5_acc_ack", 32'(ack0), 32'h1);
    send = 2'b10; tick();
    check("t5_10_release", 32'(ack0), 32'h0);
    send = 2'b00;
    repeat (6) tick();
    check("t5_err_sticky", 32'(err0), 32'h1);

    // Reset in ACK with count=3.
    handshake(16'h0101, 1'b0);
    send = 2'b01; dado = 16'h0102; tick();
    check("t6_ack", 32'(ack0), 32'h1);
    check("t6_count3", 32'(count0), 32'h3);
    #2 rst = 1'b0;
    #1;
    check("t6_async_ack", 32'(ack0), 32'h0);
    check("t6_async_empty", 32'(empty0), 32'h1);
    check("t6_async_count", 32'(count0), 32'h0);
    check("t6_async_rx", 32'(rx0), 32'h0);
    send = 2'b00;
    tick();
    rst = 1'b1;
    tick();

    // rx_total wrap.
    force d0.rx_total = 16'hFFFF;
    force d3.rx_total = 16'hFFFF;
    m_total[0] = 16'hFFFF;
    m_total[1] = 16'hFFFF;
    #1;
    release d0.rx_total;
    release d3.rx_total;
    tick();
    check("t6_preload", 32'(rx0), 32'hFFFF);
    handshake(16'h0200, 1'b0);
    check("t6_wrap0", 32'(rx0), 32'h0);
    check("t6_wrap3", 32'(rx3), 32'h0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
